// File: rtl/fast_square_pkg.sv
// fast_square_pkg: shared constants and types for the fast-square packer slice.
//   RESTART_MARKER    - I/Q word value that marks the restart of the baseband stream
//   DEFAULT_SYNC_WORD - default first header word of every frame
//   state_t           - packer FSM states
//   GRP_*_WORDS       - word counts of the pieces that make up a written group
//   SLOT_*            - writer slot indices, in the order words leave the writer
package fast_square_pkg;

  localparam logic [15:0] RESTART_MARKER    = 16'h8000;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hF5A5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    STREAM     = 2'd2
  } state_t;

  localparam int unsigned GRP_PAYLOAD_WORDS = 2;  // I, Q
  localparam int unsigned GRP_HEADER_WORDS  = 2;  // SYNC_WORD, sequence
  localparam int unsigned GRP_TRAILER_WORDS = 1;  // frame XOR

  localparam logic [2:0] SLOT_SYNC    = 3'd0;
  localparam logic [2:0] SLOT_SEQ     = 3'd1;
  localparam logic [2:0] SLOT_I       = 3'd2;
  localparam logic [2:0] SLOT_Q       = 3'd3;
  localparam logic [2:0] SLOT_TRAILER = 3'd4;

endpackage

// File: rtl/fast_square_packer_if.sv
// fast_square_packer_if: stream-side bundle of the packer.
//   in_strobe/i_in/q_in - one-cycle pulse with the I/Q sign-bit words
//   out_data/out_valid  - FIFO head word and non-empty flag
//   out_ready           - consumer accepts out_data this cycle
// Handshake: a word transfers on every clock edge where out_valid && out_ready
// are both high; out_valid never depends on out_ready, and out_data holds its
// value while out_valid is high and out_ready is low. in_strobe has no
// back-pressure: a strobe the packer cannot take is dropped and counted.
// Modports: master = source/consumer side, slave = packer.
interface fast_square_packer_if;
  logic        in_strobe;
  logic [15:0] i_in;
  logic [15:0] q_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_strobe, i_in, q_in, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_strobe, i_in, q_in, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/fs_sync_fifo.sv
// fs_sync_fifo: first-word-fall-through synchronous FIFO, 2^DEPTH_LOG2 entries.
//   clock, reset - system clock, synchronous active-high reset (empties FIFO)
//   push/push_data - write one word; ignored when full
//   pop          - remove head word; ignored when empty
//   head_data    - current head word (valid when !empty)
//   empty        - no words stored
//   free_count   - number of free entries (0..2^DEPTH_LOG2)
// A word pushed in cycle N is visible on head_data from cycle N+1.
module fs_sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   free_count
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic do_push;
  logic do_pop;

  assign empty      = (count_q == '0);
  assign free_count = cnt_t'(DEPTH) - count_q;
  assign head_data  = mem_q[rd_ptr_q];
  assign do_push    = push && (free_count != '0);
  assign do_pop     = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (do_push && !do_pop)      count_d = count_q + cnt_t'(1);
    else if (!do_push && do_pop) count_d = count_q - cnt_t'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fast_square_packer.sv
// fast_square_packer: gates the fast-square I/Q sign-bit stream with `record`,
// skips restart markers, interleaves I/Q into framed 16-bit words and buffers
// them in an FWFT FIFO toward the host RX path.
//   clock, reset       - system clock, synchronous active-high reset
//   record             - capture enable (level)
//   bus (slave)        - in_strobe/i_in/q_in in, out_data/out_valid/out_ready
//   overflow           - sticky: at least one group was dropped
//   drop_count         - dropped groups, saturating at 16'hFFFF
//   state_dbg          - current FSM state
// Optional build macro FAST_SQUARE_PACK_TRAILER_EN: the group that completes a
// frame appends the XOR of all payload words of that frame.
module fast_square_packer
  import fast_square_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned FRAME_WORDS     = 256,
  parameter logic [15:0] SYNC_WORD       = DEFAULT_SYNC_WORD
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 record,
  fast_square_packer_if.slave  bus,
  output logic                 overflow,
  output logic [15:0]          drop_count,
  output state_t               state_dbg
);
  localparam int unsigned FREE_W = FIFO_DEPTH_LOG2 + 2;

  state_t      state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] pay_q, pay_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_q, drop_d;
  logic        busy_q, busy_d;
  logic [2:0]  slot_q, slot_d;
  logic [15:0] i_q, i_d;
  logic [15:0] q_q, q_d;
  logic [15:0] grp_seq_q, grp_seq_d;
`ifdef FAST_SQUARE_PACK_TRAILER_EN
  logic [15:0] acc_q, acc_d;
  logic        trailer_q, trailer_d;
`endif

  logic              fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_free;
  logic              pop;
  logic              push;
  logic [15:0]       push_data;
  logic              hdr;
  logic              frame_end;
  logic              is_marker;
  logic              capture;
  logic              fits;
  logic              accept;
  logic              drop;
  logic [2:0]        last_slot;
  logic [FREE_W-1:0] grp_size;
  logic [FREE_W-1:0] free_avail;

  fs_sync_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (16)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (bus.out_data),
    .empty      (fifo_empty),
    .free_count (fifo_free)
  );

  assign bus.out_valid = !fifo_empty;
  assign pop           = !fifo_empty && bus.out_ready;
  assign overflow      = overflow_q;
  assign drop_count    = drop_q;
  assign state_dbg     = state_q;

  // Group decode for a strobe arriving this cycle.
  assign hdr       = (pay_q == '0);
  assign frame_end = ((pay_q + 16'(GRP_PAYLOAD_WORDS)) == 16'(FRAME_WORDS));
  assign is_marker = (bus.i_in == RESTART_MARKER) && (bus.q_in == RESTART_MARKER);
  assign capture   = record && bus.in_strobe &&
                     ((state_q == STREAM) || ((state_q == WAIT_START) && !is_marker));
  // A pop this cycle frees its slot before the group's first write lands.
  assign free_avail = {1'b0, fifo_free} + FREE_W'(pop);
  assign fits       = !busy_q && (free_avail >= grp_size);
  assign accept     = capture && fits;
  assign drop       = capture && !fits;

  always_comb begin
    grp_size = FREE_W'(GRP_PAYLOAD_WORDS);
    if (hdr) grp_size = grp_size + FREE_W'(GRP_HEADER_WORDS);
`ifdef FAST_SQUARE_PACK_TRAILER_EN
    if (frame_end) grp_size = grp_size + FREE_W'(GRP_TRAILER_WORDS);
`endif
  end

  // Writer: walks slot indices from the group's first slot to its last,
  // pushing one word per cycle.
  always_comb begin
    last_slot = SLOT_Q;
`ifdef FAST_SQUARE_PACK_TRAILER_EN
    if (trailer_q) last_slot = SLOT_TRAILER;
`endif
    push = busy_q;
    case (slot_q)
      SLOT_SYNC:    push_data = SYNC_WORD;
      SLOT_SEQ:     push_data = grp_seq_q;
      SLOT_I:       push_data = i_q;
      SLOT_Q:       push_data = q_q;
`ifdef FAST_SQUARE_PACK_TRAILER_EN
      SLOT_TRAILER: push_data = acc_q;
`endif
      default:      push_data = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    pay_d      = pay_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    busy_d     = busy_q;
    slot_d     = slot_q;
    i_d        = i_q;
    q_d        = q_q;
    grp_seq_d  = grp_seq_q;
`ifdef FAST_SQUARE_PACK_TRAILER_EN
    acc_d      = acc_q;
    trailer_d  = trailer_q;
`endif

    // FSM; the writer below runs independently so a group in flight
    // always completes even after record falls.
    case (state_q)
      IDLE: begin
        if (record) begin
          state_d    = WAIT_START;
          overflow_d = 1'b0;
          drop_d     = '0;
          seq_d      = '0;
          pay_d      = '0;
        end
      end
      WAIT_START: begin
        if (!record) state_d = IDLE;
        else if (bus.in_strobe && !is_marker) state_d = STREAM;
      end
      STREAM: begin
        if (!record) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (busy_q) begin
      if (slot_q == last_slot) busy_d = 1'b0;
      else slot_d = slot_q + 3'd1;
    end

    // accept implies !busy_q, so it never races the writer update above.
    if (accept) begin
      busy_d    = 1'b1;
      slot_d    = hdr ? SLOT_SYNC : SLOT_I;
      i_d       = bus.i_in;
      q_d       = bus.q_in;
      grp_seq_d = seq_q;
      if (hdr) seq_d = seq_q + 16'd1;
      pay_d     = frame_end ? '0 : (pay_q + 16'(GRP_PAYLOAD_WORDS));
`ifdef FAST_SQUARE_PACK_TRAILER_EN
      // Writer reads acc_q for the trailer; no new group can be accepted
      // until that word has been written.
      acc_d     = (hdr ? 16'h0000 : acc_q) ^ bus.i_in ^ bus.q_in;
      trailer_d = frame_end;
`endif
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      pay_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      busy_q     <= 1'b0;
      slot_q     <= SLOT_SYNC;
      i_q        <= '0;
      q_q        <= '0;
      grp_seq_q  <= '0;
`ifdef FAST_SQUARE_PACK_TRAILER_EN
      acc_q      <= '0;
      trailer_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      pay_q      <= pay_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      slot_q     <= slot_d;
      i_q        <= i_d;
      q_q        <= q_d;
      grp_seq_q  <= grp_seq_d;
`ifdef FAST_SQUARE_PACK_TRAILER_EN
      acc_q      <= acc_d;
      trailer_q  <= trailer_d;
`endif
    end
  end

endmodule

// File: tb/tb_fast_square_packer.sv
// tb_fast_square_packer: directed bench for fast_square_packer with a
// scoreboard queue of expected output words (FRAME_WORDS=4, depth 16).
module tb_fast_square_packer;
  import fast_square_pkg::*;

  localparam int FW    = 4;
  localparam int DEPTH = 16;

  // Clock / reset
  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        record = 1'b0;
  logic        overflow;
  logic [15:0] drop_count;
  state_t      state_dbg;

  fast_square_packer_if bus ();

  fast_square_packer #(
    .FIFO_DEPTH_LOG2 (4),
    .FRAME_WORDS     (FW),
    .SYNC_WORD       (16'hF5A5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .record     (record),
    .bus        (bus.slave),
    .overflow   (overflow),
    .drop_count (drop_count),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state and reference model
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          m_pay   = 0;
  logic [15:0] m_seq   = 16'h0000;
  logic [15:0] m_acc   = 16'h0000;
  int          m_drops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int gsize();
    int s;
    s = (m_pay == 0) ? 4 : 2;
`ifdef FAST_SQUARE_PACK_TRAILER_EN
    if (m_pay + 2 == FW) s = s + 1;
`endif
    return s;
  endfunction

  task automatic model_accept(input logic [15:0] i, input logic [15:0] q);
    if (m_pay == 0) begin
      exp_q.push_back(16'hF5A5);
      exp_q.push_back(m_seq);
      m_seq = m_seq + 16'd1;
      m_acc = 16'h0000;
    end
    exp_q.push_back(i);
    exp_q.push_back(q);
    m_acc = m_acc ^ i ^ q;
    m_pay = m_pay + 2;
    if (m_pay == FW) begin
`ifdef FAST_SQUARE_PACK_TRAILER_EN
      exp_q.push_back(m_acc);
`endif
      m_pay = 0;
    end
  endtask

  // mode: 0 = ignored, 1 = accepted, 2 = dropped and counted
  task automatic send(input logic [15:0] i, input logic [15:0] q, input int mode);
    bus.in_strobe = 1'b1;
    bus.i_in      = i;
    bus.q_in      = q;
    if (mode == 1) model_accept(i, q);
    else if (mode == 2) m_drops++;
    tick(1);
    bus.in_strobe = 1'b0;
    tick(15);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    tick(2);
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", bus.out_valid, 1'b0);
  endtask

  task automatic restart();
    record = 1'b0;
    tick(2);
    check("restart_idle", state_dbg, IDLE);
    record = 1'b1;
    tick(2);
    m_pay   = 0;
    m_seq   = 16'h0000;
    m_drops = 0;
    check("restart_state", state_dbg, WAIT_START);
    check("restart_overflow", overflow, 1'b0);
    check("restart_drops", drop_count, 16'h0000);
  endtask

  // Output monitor: compares every transferred word against the queue and
  // checks head stability while stalled.
  logic        hold = 1'b0;
  logic [15:0] last_data = 16'h0000;
  always @(negedge clock) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) check("hold_stable", bus.out_data, last_data);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_word: observed %h expected none", bus.out_data);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
        end
      end
      hold      = bus.out_valid && !bus.out_ready;
      last_data = bus.out_data;
    end
  end

  initial begin
    bus.in_strobe = 1'b0;
    bus.i_in      = 16'h0000;
    bus.q_in      = 16'h0000;
    bus.out_ready = 1'b0;

    // Reset state
    tick(3);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drops", drop_count, 16'h0000);
    check("rst_state", state_dbg, IDLE);
    reset = 1'b0;
    tick(2);

    // Marker skip and first-group latency
    bus.out_ready = 1'b1;
    restart();
    send(16'h8000, 16'h8000, 0);
    send(16'h8000, 16'h8000, 0);
    send(16'h8000, 16'h8000, 0);
    check("marker_state", state_dbg, WAIT_START);
    check("marker_valid", bus.out_valid, 1'b0);
    bus.in_strobe = 1'b1;
    bus.i_in      = 16'h1234;
    bus.q_in      = 16'h5678;
    model_accept(16'h1234, 16'h5678);
    tick(1);
    bus.in_strobe = 1'b0;
    check("lat_t1_valid", bus.out_valid, 1'b0);
    tick(1);
    check("lat_t2_valid", bus.out_valid, 1'b1);
    check("lat_t2_data", bus.out_data, 16'hF5A5);
    tick(14);
    check("stream_state", state_dbg, STREAM);
    drain();

    // Framing across a frame boundary
    restart();
    send(16'h0001, 16'h0002, 1);
    send(16'h0003, 16'h0004, 1);
    send(16'h0005, 16'h0006, 1);
    drain();

    // Overflow with a stalled consumer
    restart();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (exp_q.size() + gsize() <= DEPTH) begin
        send(16'h0100 + 16'(k), 16'h0200 + 16'(k), 1);
      end else begin
        send(16'h0100 + 16'(k), 16'h0200 + 16'(k), 2);
        break;
      end
    end
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drops", drop_count, 16'(m_drops));
    check("ovf_valid", bus.out_valid, 1'b1);
    drain();
    send(16'h0A0A, 16'h0B0B, 1);
    drain();
    check("ovf_drops_after", drop_count, 16'(m_drops));

    // Busy collision: second strobe lands while a header group is written
    restart();
    bus.in_strobe = 1'b1;
    bus.i_in      = 16'h00A1;
    bus.q_in      = 16'h00A2;
    model_accept(16'h00A1, 16'h00A2);
    tick(1);
    bus.in_strobe = 1'b0;
    tick(1);
    bus.in_strobe = 1'b1;
    bus.i_in      = 16'h00B1;
    bus.q_in      = 16'h00B2;
    m_drops++;
    tick(1);
    bus.in_strobe = 1'b0;
    tick(14);
    check("busy_drops", drop_count, 16'(m_drops));
    check("busy_overflow", overflow, 1'b1);
    drain();

    // Record falls the cycle after a strobe
    bus.in_strobe = 1'b1;
    bus.i_in      = 16'h00C1;
    bus.q_in      = 16'h00C2;
    model_accept(16'h00C1, 16'h00C2);
    tick(1);
    bus.in_strobe = 1'b0;
    record        = 1'b0;
    tick(15);
    send(16'h00D1, 16'h00D2, 0);
    drain();
    check("fall_state", state_dbg, IDLE);
    check("fall_drops", drop_count, 16'(m_drops));
    restart();
    send(16'h00E1, 16'h00E2, 1);
    send(16'h8000, 16'h8000, 1);
    drain();

    // Reset mid-operation discards buffered words
    bus.out_ready = 1'b0;
    send(16'h00F1, 16'h00F2, 1);
    reset = 1'b1;
    tick(2);
    exp_q.delete();
    check("midrst_valid", bus.out_valid, 1'b0);
    check("midrst_state", state_dbg, IDLE);
    check("midrst_overflow", overflow, 1'b0);
    reset  = 1'b0;
    record = 1'b0;
    tick(2);
    check("midrst_idle_valid", bus.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
